// File: rtl/host_wb_loader.sv
// Host byte stream to Wishbone write loader; holds the CPU in reset until the load is complete.
// Optional read-back verify: define HOSTLOAD_READBACK_EN.
module host_wb_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h00000000,
    parameter logic [31:0] MEM_SIZE  = 32'h02000000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    input  logic        done_i,
    output logic        ack_data_o,
    output logic        ack_o,
    output logic        cpu_rst_o,
    output logic        err_o,
    output logic        ovf_o,
`ifdef HOSTLOAD_READBACK_EN
    output logic        verify_err_o,
`endif
    output logic [23:0] words_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic [2:0] {
        COLLECT, WRITE, FLUSH, DONE
`ifdef HOSTLOAD_READBACK_EN
        , READBACK
`endif
    } state_t;

    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + {1'b0, MEM_SIZE};

    state_t      state;
    logic        seen;
    logic [1:0]  cnt;
    logic [23:0] bytes_q;
    logic        accept;
    logic        room;
    logic        bus_done;
    logic [31:0] flush_dat;
    logic [3:0]  flush_sel;
    logic [23:0] words_inc;

    assign wb_cti_o = 3'b000;
    assign wb_bte_o = 2'b00;

    assign accept    = (state == COLLECT) && valid_i && !seen;
    assign room      = ({1'b0, wb_adr_o} < LIMIT);
    assign bus_done  = wb_ack_i | wb_err_i;
    assign words_inc = (&words_o) ? words_o : words_o + 24'd1;

    always_comb begin
        flush_dat = 32'h0;
        flush_sel = 4'b0000;
        unique case (cnt)
            2'd1: begin flush_dat = {bytes_q[7:0], 24'h0};  flush_sel = 4'b1000; end
            2'd2: begin flush_dat = {bytes_q[15:0], 16'h0}; flush_sel = 4'b1100; end
            2'd3: begin flush_dat = {bytes_q, 8'h0};        flush_sel = 4'b1110; end
            default: ;
        endcase
    end

`ifdef HOSTLOAD_READBACK_EN
    logic [3:0]  wr_sel;
    logic        last;
    logic [31:0] rb_mask;
    assign rb_mask = {{8{wr_sel[3]}}, {8{wr_sel[2]}}, {8{wr_sel[1]}}, {8{wr_sel[0]}}};
`else
    logic unused_rd;
    assign unused_rd = ^wb_dat_i;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= COLLECT;
            seen       <= 1'b0;
            cnt        <= 2'd0;
            bytes_q    <= 24'h0;
            ack_data_o <= 1'b0;
            ack_o      <= 1'b0;
            cpu_rst_o  <= 1'b1;
            err_o      <= 1'b0;
            ovf_o      <= 1'b0;
            words_o    <= 24'h0;
            wb_adr_o   <= BASE_ADDR;
            wb_dat_o   <= 32'h0;
            wb_sel_o   <= 4'h0;
            wb_we_o    <= 1'b0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
`ifdef HOSTLOAD_READBACK_EN
            verify_err_o <= 1'b0;
            wr_sel       <= 4'h0;
            last         <= 1'b0;
`endif
        end else begin
            ack_data_o <= accept;
            if (!valid_i)
                seen <= 1'b0;
            else if (accept)
                seen <= 1'b1;

            case (state)
                COLLECT: begin
                    if (accept) begin
                        bytes_q <= {bytes_q[15:0], data_i};
                        cnt     <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            if (room) begin
                                wb_dat_o <= {bytes_q, data_i};
                                wb_sel_o <= 4'hF;
                                wb_we_o  <= 1'b1;
                                wb_cyc_o <= 1'b1;
                                wb_stb_o <= 1'b1;
                                state    <= WRITE;
                            end else begin
                                ovf_o <= 1'b1;
                            end
                        end
                    end else if (done_i) begin
                        cnt <= 2'd0;
                        if (cnt != 2'd0 && room) begin
                            wb_dat_o <= flush_dat;
                            wb_sel_o <= flush_sel;
                            wb_we_o  <= 1'b1;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            state    <= FLUSH;
                        end else begin
                            if (cnt != 2'd0)
                                ovf_o <= 1'b1;
                            ack_o     <= 1'b1;
                            cpu_rst_o <= 1'b0;
                            state     <= DONE;
                        end
                    end
                end
                WRITE, FLUSH: begin
                    if (bus_done) begin
                        if (wb_err_i)
                            err_o <= 1'b1;
`ifdef HOSTLOAD_READBACK_EN
                        if (!wb_err_i) begin
                            wb_we_o  <= 1'b0;
                            wr_sel   <= wb_sel_o;
                            wb_sel_o <= 4'hF;
                            last     <= (state == FLUSH);
                            state    <= READBACK;
                        end else
`endif
                        begin
                            wb_cyc_o <= 1'b0;
                            wb_stb_o <= 1'b0;
                            wb_we_o  <= 1'b0;
                            wb_adr_o <= wb_adr_o + 32'd4;
                            words_o  <= words_inc;
                            if (state == FLUSH) begin
                                ack_o     <= 1'b1;
                                cpu_rst_o <= 1'b0;
                                state     <= DONE;
                            end else begin
                                state <= COLLECT;
                            end
                        end
                    end
                end
`ifdef HOSTLOAD_READBACK_EN
                READBACK: begin
                    if (bus_done) begin
                        if (wb_err_i)
                            err_o <= 1'b1;
                        else if (((wb_dat_i ^ wb_dat_o) & rb_mask) != 32'h0)
                            verify_err_o <= 1'b1;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_adr_o <= wb_adr_o + 32'd4;
                        words_o  <= words_inc;
                        if (last) begin
                            ack_o     <= 1'b1;
                            cpu_rst_o <= 1'b0;
                            state     <= DONE;
                        end else begin
                            state <= COLLECT;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_host_wb_loader.sv
// Directed bench for host_wb_loader: vector table plus multi-cycle corner sequences.
// Small MEM_SIZE so the overflow path is reachable.
module tb_host_wb_loader;

    localparam logic [31:0] BASE = 32'h00000100;
    localparam logic [31:0] MSZ  = 32'd8;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data;
    logic        valid;
    logic        done;
    logic        ack_data_o, ack_o, cpu_rst_o, err_o, ovf_o;
    logic [23:0] words_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
`ifdef HOSTLOAD_READBACK_EN
    logic        verify_err_o;
`endif

    always #5 clk = ~clk;

    host_wb_loader #(.BASE_ADDR(BASE), .MEM_SIZE(MSZ)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .data_i(data), .valid_i(valid), .done_i(done),
        .ack_data_o(ack_data_o), .ack_o(ack_o), .cpu_rst_o(cpu_rst_o),
        .err_o(err_o), .ovf_o(ovf_o),
`ifdef HOSTLOAD_READBACK_EN
        .verify_err_o(verify_err_o),
`endif
        .words_o(words_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wr_t;

    wr_t         log_q[$];
    int          ntx = 0;
    int          err_idx = -1;
    int          dly = 0;
    int          wcnt = 0;
    int          nack = 0;
    logic [31:0] corrupt = 32'h0;
    logic [31:0] mem [0:15];
    logic        bus_go;
    int          n_cmp = 0;
    int          n_bad = 0;

    assign bus_go   = wb_cyc_o && wb_stb_o && (wcnt >= dly);
    assign wb_ack_i = bus_go && (ntx != err_idx);
    assign wb_err_i = bus_go && (ntx == err_idx);
    assign wb_dat_i = mem[wb_adr_o[5:2]] ^ corrupt;

    always @(posedge clk) begin
        if (!(wb_cyc_o && wb_stb_o) || wb_ack_i || wb_err_i)
            wcnt <= 0;
        else
            wcnt <= wcnt + 1;
        if (wb_cyc_o && wb_stb_o && (wb_ack_i || wb_err_i)) begin
            ntx <= ntx + 1;
            if (wb_we_o) begin
                log_q.push_back('{wb_adr_o, wb_dat_o, wb_sel_o});
                mem[wb_adr_o[5:2]] <= wb_dat_o;
            end
        end
        if (ack_data_o)
            nack <= nack + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b0;
        done  = 1'b0;
        data  = 8'h00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int t;
        valid = 1'b1;
        data  = b;
        t = 0;
        while (!ack_data_o && t < 80) begin
            tick();
            t++;
        end
        if (!ack_data_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL byte_timeout: byte %h got no ack_data_o", b);
        end
        valid = 1'b0;
        tick();
    endtask

    task automatic finish_load();
        int t;
        done = 1'b1;
        t = 0;
        while (!ack_o && t < 80) begin
            tick();
            t++;
        end
        if (!ack_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: ack_o never rose");
        end
        done = 1'b0;
        tick();
    endtask

    task automatic chk_wr(input string nm, input int idx, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
        if (idx < log_q.size()) begin
            chk({nm, "_adr"}, log_q[idx].adr, adr);
            chk({nm, "_dat"}, log_q[idx].dat, dat);
            chk({nm, "_sel"}, 32'(log_q[idx].sel), 32'(sel));
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_missing: got %0d writes want > %0d", nm, log_q.size(), idx);
        end
    endtask

    typedef struct {
        int          n;
        logic [31:0] bytes;
        logic [31:0] dat;
        logic [3:0]  sel;
    } vec_t;

    vec_t v[5];

    initial begin
        int l0, a0;
        logic [31:0] tmp;

        v[0] = '{4, 32'hDEADBEEF, 32'hDEADBEEF, 4'hF};
        v[1] = '{3, 32'h11223300, 32'h11223300, 4'b1110};
        v[2] = '{2, 32'hA5C30000, 32'hA5C30000, 4'b1100};
        v[3] = '{1, 32'h7F000000, 32'h7F000000, 4'b1000};
        v[4] = '{0, 32'h00000000, 32'h00000000, 4'b0000};

        do_reset();
        chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_we", 32'(wb_we_o), 32'd0);
        chk("rst_sel", 32'(wb_sel_o), 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_adr", wb_adr_o, BASE);
        chk("rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_ack_data", 32'(ack_data_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_ovf", 32'(ovf_o), 32'd0);
        chk("rst_words", 32'(words_o), 32'd0);
        chk("rst_cti_bte", {27'd0, wb_cti_o, wb_bte_o}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            do_reset();
            l0 = log_q.size();
            a0 = nack;
            for (int k = 0; k < v[i].n; k++) begin
                tmp = v[i].bytes >> (24 - 8 * k);
                send(tmp[7:0]);
            end
            if (v[i].n == 4) begin
                chk("vec_words_pre_done", 32'(words_o), 32'd1);
                chk("vec_cpu_rst_pre_done", 32'(cpu_rst_o), 32'd1);
            end
            finish_load();
            chk($sformatf("vec%0d_nwr", i), log_q.size() - l0, (v[i].n > 0) ? 1 : 0);
            if (v[i].n > 0)
                chk_wr($sformatf("vec%0d", i), l0, BASE, v[i].dat, v[i].sel);
            chk($sformatf("vec%0d_acks", i), nack - a0, v[i].n);
            chk($sformatf("vec%0d_words", i), 32'(words_o), (v[i].n > 0) ? 1 : 0);
            chk($sformatf("vec%0d_ack_o", i), 32'(ack_o), 32'd1);
            chk($sformatf("vec%0d_cpu_rst", i), 32'(cpu_rst_o), 32'd0);
        end

        // six bytes then done: one full word plus a two-byte flush
        do_reset();
        l0 = log_q.size();
        for (int k = 1; k <= 6; k++)
            send(8'(k));
        chk("six_cpu_rst_loading", 32'(cpu_rst_o), 32'd1);
        finish_load();
        chk("six_nwr", log_q.size() - l0, 2);
        chk_wr("six_w0", l0, BASE, 32'h01020304, 4'hF);
        chk_wr("six_w1", l0 + 1, BASE + 4, 32'h05060000, 4'b1100);
        chk("six_words", 32'(words_o), 32'd2);
        chk("six_ack_o", 32'(ack_o), 32'd1);
        chk("six_cpu_rst", 32'(cpu_rst_o), 32'd0);
        valid = 1'b1;
        data  = 8'h99;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("done_ignores_valid", 32'(ack_data_o), 32'd0);
        end
        valid = 1'b0;

        // held valid yields one byte; slow ack keeps the bus stable
        do_reset();
        dly = 5;
        a0 = nack;
        valid = 1'b1;
        data  = 8'h11;
        for (int k = 0; k < 10; k++)
            tick();
        valid = 1'b0;
        tick();
        chk("held_one_ack", nack - a0, 1);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        valid = 1'b1;
        data  = 8'h55;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("slow_cyc", 32'(wb_cyc_o), 32'd1);
            chk("slow_we", 32'(wb_we_o), 32'd1);
            chk("slow_adr", wb_adr_o, BASE);
            chk("slow_dat", wb_dat_o, 32'h11223344);
            chk("slow_sel", 32'(wb_sel_o), 32'hF);
            chk("slow_no_accept", 32'(ack_data_o), 32'd0);
        end
        send(8'h55);
        chk("slow_words", 32'(words_o), 32'd1);
        chk("slow_adr_next", wb_adr_o, BASE + 4);
        chk("slow_bytes", nack - a0, 5);
        dly = 0;

        // bus error on the first word: flagged, address still advances
        do_reset();
        l0 = log_q.size();
        err_idx = ntx;
        for (int k = 0; k < 4; k++)
            send(8'hA0 + 8'(k));
        err_idx = -1;
        chk("err_flag", 32'(err_o), 32'd1);
        chk("err_adr", wb_adr_o, BASE + 4);
        for (int k = 0; k < 4; k++)
            send(8'hB0 + 8'(k));
        chk_wr("err_w1", l0 + 1, BASE + 4, 32'hB0B1B2B3, 4'hF);
        chk("err_sticky", 32'(err_o), 32'd1);

        // overflow: third word lies past MEM_SIZE
        do_reset();
        l0 = log_q.size();
        a0 = nack;
        for (int k = 0; k < 12; k++)
            send(8'hC0 + 8'(k));
        tick();
        chk("ovf_nwr", log_q.size() - l0, 2);
        chk("ovf_flag", 32'(ovf_o), 32'd1);
        chk("ovf_acks", nack - a0, 12);
        chk("ovf_words", 32'(words_o), 32'd2);
        chk("ovf_cyc_idle", 32'(wb_cyc_o), 32'd0);
        chk_wr("ovf_w1", l0 + 1, BASE + 4, 32'hC4C5C6C7, 4'hF);

        // reset in the middle of a write aborts the cycle
        do_reset();
        dly = 20;
        for (int k = 0; k < 4; k++)
            send(8'hE0 + 8'(k));
        chk("mid_cyc_before", 32'(wb_cyc_o), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_cyc", 32'(wb_cyc_o), 32'd0);
        chk("mid_stb", 32'(wb_stb_o), 32'd0);
        chk("mid_adr", wb_adr_o, BASE);
        chk("mid_cpu_rst", 32'(cpu_rst_o), 32'd1);
        chk("mid_words", 32'(words_o), 32'd0);
        rst = 1'b0;
        dly = 0;
        tick();

`ifdef HOSTLOAD_READBACK_EN
        do_reset();
        for (int k = 0; k < 4; k++)
            send(8'h10 + 8'(k));
        chk("rb_clean", 32'(verify_err_o), 32'd0);
        chk("rb_words", 32'(words_o), 32'd1);
        corrupt = 32'h00000001;
        for (int k = 0; k < 4; k++)
            send(8'h20 + 8'(k));
        corrupt = 32'h0;
        chk("rb_verify_err", 32'(verify_err_o), 32'd1);
        chk("rb_adr", wb_adr_o, BASE + 8);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/host_wb_loader.md
Name: host_wb_loader

Overview:
- Byte-stream to Wishbone write master. Sits between the host byte interface and the memory bus.
- Packs host bytes into big-endian 32-bit words and writes them to main memory from BASE_ADDR upward.
- Holds the CPU in reset until the host signals load complete, then releases it.
- Its host-facing ports feed the host control signals at the SoC top; its Wishbone master connects as a master on the interconnect.

Parameters:
- BASE_ADDR, 32'h00000000, byte address of the first word written.
- MEM_SIZE, 32'h02000000, bytes available from BASE_ADDR; writes beyond it are suppressed.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- data_i  in  8  host byte
- valid_i  in  1  host byte valid (level, held until ack_data_o)
- done_i  in  1  host finished sending (level, held until ack_o)
- ack_data_o  out  1  one-cycle pulse, byte accepted
- ack_o  out  1  load complete (level)
- cpu_rst_o  out  1  CPU reset request
- err_o  out  1  sticky, bus error seen
- ovf_o  out  1  sticky, data past MEM_SIZE discarded
- words_o  out  24  words written
- wb_adr_o  out  32  Wishbone address
- wb_dat_o  out  32  write data
- wb_sel_o  out  4  byte select
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe
- wb_cti_o  out  3  fixed 3'b000
- wb_bte_o  out  2  fixed 2'b00
- wb_dat_i  in  32  read data (used only by the optional feature)
- wb_ack_i  in  1  ack
- wb_err_i  in  1  error

Behaviour:
- Reset values:
  - cyc, stb, we, sel, dat: 0.
  - adr: BASE_ADDR.
  - cpu_rst_o: 1.
  - ack_o, ack_data_o, err_o, ovf_o: 0.
  - words_o: 0; byte count: 0.
  - State: COLLECT.
- Reset mid-bus-cycle aborts the cycle: cyc/stb are 0 after the reset edge. No completion is awaited.
- States: COLLECT, WRITE, FLUSH, DONE.
- Byte acceptance (COLLECT only):
  - A byte is accepted when valid_i=1 and the seen flag is 0.
  - Acceptance sets the seen flag; the flag clears when valid_i=0. One held valid therefore yields exactly one byte.
  - ack_data_o pulses high in the cycle after acceptance.
- Byte placement, big-endian:
  - Byte 0 goes to [31:24], byte 1 to [23:16], byte 2 to [15:8], byte 3 to [7:0].
- Word completion:
  - The 4th accepted byte moves the state to WRITE.
  - cyc=stb=we=1 and sel=4'hF at the next edge. Latency from 4th byte to cyc is 1 cycle.
- WRITE:
  - Outputs are held stable until wb_ack_i or wb_err_i.
  - On either, drop cyc/stb/we at the next edge, adr += 4, words_o += 1, and return to COLLECT.
  - wb_err_i also sets err_o.
  - valid_i arriving during WRITE is not lost: it is accepted on return to COLLECT.
- done_i in COLLECT:
  - Byte count 0: go to DONE.
  - Otherwise go to FLUSH, a single write with sel = 4'b1000, 4'b1100 or 4'b1110 for 1, 2 or 3 bytes. Unused data bytes are 0. Then go to DONE.
- Simultaneous new byte and done_i in the same cycle: the byte is accepted first; done_i is acted on the next cycle.
- Overflow:
  - If adr >= BASE_ADDR+MEM_SIZE when a word completes, no bus cycle is issued and ovf_o is set.
  - Bytes are still acked; words_o does not increment.
- DONE:
  - cpu_rst_o=0 and ack_o=1 at entry, held until reset.
  - valid_i is ignored and no ack_data_o is issued.
- words_o saturates at all-ones.

Optional Feature:
- Macro: HOSTLOAD_READBACK_EN.
- Defined:
  - After each write ack, a READBACK state issues a single read (we=0, same adr, sel=4'hF).
  - On ack, wb_dat_i is compared against the written data under sel mask. A mismatch sets sticky output verify_err_o.
  - adr/words_o advance only after readback; write-to-COLLECT latency grows by one bus cycle.
  - A readback wb_err_i sets err_o.
- Undefined:
  - No READBACK state.
  - verify_err_o is absent from the port list.

Test Plan:
- Reset, then bytes 0xDE,0xAD,0xBE,0xEF with ack zero-wait → one write: adr=BASE_ADDR, dat=32'hDEADBEEF, sel=4'hF. words_o=1; four ack_data_o pulses; cpu_rst_o=1.
- 6 bytes 0x01..0x06, then done_i → writes 32'h01020304 sel F at BASE, then 32'h05060000 sel 4'b1100 at BASE+4. ack_o=1, cpu_rst_o=0.
- valid_i held 10 cycles for one byte → exactly one ack_data_o. Ack delayed 5 cycles during WRITE → bus signals stable; next byte accepted after ack.
- wb_err_i instead of ack on the first word → err_o=1, adr advances to BASE+4, loading continues.
- MEM_SIZE=8, 12 bytes → two writes, third word suppressed. ovf_o=1, all 12 bytes acked.
- wb_rst_i asserted mid-WRITE → cyc=0 next edge, adr=BASE_ADDR, cpu_rst_o=1. With HOSTLOAD_READBACK_EN, a corrupted readback sets verify_err_o=1.
